uart_tx_ctrl: RTL and testbench

- UART transmit controller for the ispMACH 4256ZE breakout board, clocked from the 5 MHz on-chip oscillator output (osc_clk).
- Accepts bytes over a valid/ready handshake and derives baud timing by dividing osc_clk.
- Serialises each byte as 8N1 (or 8N2) on txd, LSB first.
- Drives an active-low activity LED with a retriggerable stretch so short frames are visible. Instantiated beside the oscillator in the top level.

---
 rtl/uart_tx_ctrl.sv | 152 +++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: accepts bytes on a valid/ready handshake, sends them 8N1/8N2
// LSB first on a registered txd, and stretches an active-low activity LED.
module uart_tx_ctrl #(
  parameter int unsigned CLK_DIV     = 521,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned LED_STRETCH = 250000
) (
  input  logic       osc_clk,
  input  logic       nrst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       busy,
  output logic       tx_done,
  output logic       nled_act
);

  localparam int unsigned BAUD_W = $clog2(CLK_DIV);
  localparam int unsigned LED_W  = $clog2(LED_STRETCH + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [LED_W-1:0]  LED_LOAD  = LED_W'(LED_STRETCH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic              txd_q, txd_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              nled_q, nled_d;
  logic              accept;
  logic              bit_end;

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    done_d    = 1'b0;
    led_d     = (led_q != '0) ? led_q - 1'b1 : led_q;
    accept    = tx_valid && ready_q;
    bit_end   = (baud_q == BAUD_LAST);

    if (state_q != IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = START;
          shift_d   = tx_data;
          txd_d     = 1'b0;
          baud_d    = '0;
          bit_cnt_d = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          txd_d     = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        // shift_q[0] always holds the bit that goes out at the next boundary
        if (bit_end) begin
          if (bit_cnt_q == 3'd7) begin
            state_d   = STOP;
            txd_d     = 1'b1;
            bit_cnt_d = '0;
          end else begin
            txd_d     = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_cnt_q == STOP_LAST) begin
            state_d   = IDLE;
            done_d    = 1'b1;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase

    if (accept) begin
      led_d = LED_LOAD;
    end

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    nled_d  = (led_d == '0);
  end

  // ready is low throughout reset and rises on the first edge after release
  always_ff @(posedge osc_clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      led_q     <= '0;
      txd_q     <= 1'b1;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      nled_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      led_q     <= led_d;
      txd_q     <= txd_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      nled_q    <= nled_d;
    end
  end

  assign tx_ready = ready_q;
  assign txd      = txd_q;
  assign busy     = busy_q;
  assign tx_done  = done_q;
  assign nled_act = nled_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: an 8N1 instance and an 8N2 instance at CLK_DIV=4,
// frames checked by a txd-decoding monitor against a scoreboard queue.
module tb_uart_tx_ctrl;

  localparam int DIV = 4;

  typedef struct {
    int         dut;
    logic [7:0] data;
    int         stop;
    int         gap;
  } exp_t;

  logic       clk;
  logic       nrst;
  logic [7:0] tx_data;
  logic       tx_valid1, tx_valid2;
  logic       tx_ready1, tx_ready2;
  logic       txd1, txd2;
  logic       busy1, busy2;
  logic       done1, done2;
  logic       nled1, nled2;

  logic [1:0] busy_v, txd_v, done_v;
  assign busy_v = {busy2, busy1};
  assign txd_v  = {txd2, txd1};
  assign done_v = {done2, done1};

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int   frm_len  [2];
  int   idle_run [2];
  int   gap_v    [2];
  logic trace    [2][64];
  logic prev_busy[2];
  logic prev_done[2];

  uart_tx_ctrl #(.CLK_DIV(DIV), .STOP_BITS(1), .LED_STRETCH(50)) dut1 (
    .osc_clk (clk),
    .nrst    (nrst),
    .tx_data (tx_data),
    .tx_valid(tx_valid1),
    .tx_ready(tx_ready1),
    .txd     (txd1),
    .busy    (busy1),
    .tx_done (done1),
    .nled_act(nled1)
  );

  uart_tx_ctrl #(.CLK_DIV(DIV), .STOP_BITS(2), .LED_STRETCH(20)) dut2 (
    .osc_clk (clk),
    .nrst    (nrst),
    .tx_data (tx_data),
    .tx_valid(tx_valid2),
    .tx_ready(tx_ready2),
    .txd     (txd2),
    .busy    (busy2),
    .tx_done (done2),
    .nled_act(nled2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drives one byte to DUT d and waits for its acceptance edge; optionally keeps
  // tx_valid high and switches tx_data just after acceptance.
  task automatic applyStimulus(input int d, input logic [7:0] data, input int gap,
                               input bit expect_done, input bit keep, input logic [7:0] next);
    bit   ok;
    exp_t e;
    ok = 0;
    @(negedge clk);
    tx_data = data;
    if (d == 0) tx_valid1 = 1'b1; else tx_valid2 = 1'b1;
    for (int k = 0; k < 200 && !ok; k++) begin
      if ((d == 0) ? tx_ready1 : tx_ready2) begin
        @(posedge clk);
        if (expect_done) begin
          e.dut  = d;
          e.data = data;
          e.stop = (d == 0) ? 1 : 2;
          e.gap  = gap;
          sb.push_back(e);
        end
        ok = 1;
        #1;
        tx_data = next;
        if (!keep) begin
          tx_valid1 = 1'b0;
          tx_valid2 = 1'b0;
        end
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic measureLed(output int low);
    int k;
    low = 0;
    k   = 0;
    @(negedge clk);
    while (nled1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    while (!nled1 && low < 500) begin
      low++;
      @(negedge clk);
    end
  endtask

  task automatic waitIdle();
    for (int k = 0; k < 300 && sb.size() != 0; k++) @(negedge clk);
    checkOutput("scoreboard_drained", sb.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // Monitor: records each busy window of txd and scores it when tx_done pulses.
  always @(negedge clk) begin : monitor
    exp_t       e;
    int         errs;
    int         elen;
    int         kk;
    logic       ebit;
    logic [7:0] dec;
    for (int i = 0; i < 2; i++) begin
      if (!nrst) begin
        frm_len[i]   = 0;
        idle_run[i]  = 0;
        gap_v[i]     = 0;
        prev_busy[i] = 1'b0;
        prev_done[i] = 1'b0;
      end else begin
        if (busy_v[i]) begin
          if (!prev_busy[i]) begin
            gap_v[i]   = idle_run[i];
            frm_len[i] = 0;
          end
          if (frm_len[i] < 64) trace[i][frm_len[i]] = txd_v[i];
          frm_len[i]++;
          idle_run[i] = 0;
        end else begin
          idle_run[i]++;
        end
        if (done_v[i]) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_tx_done", 1, 0);
          end else begin
            e    = sb.pop_front();
            elen = (9 + e.stop) * DIV;
            checkOutput("frame_dut", i, e.dut);
            checkOutput("frame_len", frm_len[i], elen);
            for (int b = 0; b < 8; b++) dec[b] = trace[i][(b + 1) * DIV + DIV / 2];
            checkOutput("frame_byte", int'(dec), int'(e.data));
            errs = 0;
            for (int j = 0; j < elen && j < 64; j++) begin
              kk   = j / DIV;
              ebit = (kk == 0) ? 1'b0 : (kk <= 8) ? e.data[kk - 1] : 1'b1;
              if (j >= frm_len[i] || trace[i][j] !== ebit) errs++;
            end
            checkOutput("frame_trace_errs", errs, 0);
            if (e.gap >= 0) checkOutput("frame_gap", gap_v[i], e.gap);
            checkOutput("done_width", int'(prev_done[i]), 0);
          end
        end
        prev_busy[i] = busy_v[i];
        prev_done[i] = done_v[i];
      end
    end
  end

  initial begin
    int led_low;
    int bad;
    int dones;
    nrst      = 1'b0;
    tx_data   = 8'h00;
    tx_valid1 = 1'b0;
    tx_valid2 = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset_txd", int'(txd1), 1);
    checkOutput("reset_tx_ready", int'(tx_ready1), 0);
    checkOutput("reset_busy", int'(busy1), 0);
    checkOutput("reset_tx_done", int'(done1), 0);
    checkOutput("reset_nled", int'(nled1), 1);
    checkOutput("reset_txd2", int'(txd2), 1);

    nrst = 1'b1;
    #1;
    checkOutput("ready_before_first_edge", int'(tx_ready1), 0);
    @(posedge clk);
    #1;
    checkOutput("ready_after_first_edge", int'(tx_ready1), 1);
    checkOutput("ready2_after_first_edge", int'(tx_ready2), 1);
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (txd1 !== 1'b1 || busy1 !== 1'b0 || tx_ready1 !== 1'b1 || nled1 !== 1'b1 || done1 !== 1'b0)
        bad++;
    end
    checkOutput("idle_stable_bad_cycles", bad, 0);

    $display("[TB] single frame 0x55, 8N1");
    fork
      applyStimulus(0, 8'h55, -1, 1, 0, 8'h00);
      measureLed(led_low);
    join
    checkOutput("led_single_low_cycles", led_low, 50);
    waitIdle();

    $display("[TB] back-to-back 0xA5 then 0x3C, LED retrigger");
    fork
      begin
        applyStimulus(0, 8'hA5, -1, 1, 1, 8'h3C);
        applyStimulus(0, 8'h3C, 1, 1, 0, 8'h00);
      end
      measureLed(led_low);
    join
    checkOutput("led_retrigger_low_cycles", led_low, 91);
    waitIdle();

    $display("[TB] 0x00 with two stop bits");
    applyStimulus(1, 8'h00, -1, 1, 0, 8'h00);
    waitIdle();

    $display("[TB] reset during data bit 3 of 0xFF");
    applyStimulus(0, 8'hFF, -1, 0, 0, 8'h00);
    repeat (17) @(negedge clk);
    checkOutput("abort_busy_before_reset", int'(busy1), 1);
    #2;
    nrst = 1'b0;
    #1;
    checkOutput("abort_txd_async", int'(txd1), 1);
    checkOutput("abort_busy_async", int'(busy1), 0);
    checkOutput("abort_ready_async", int'(tx_ready1), 0);
    checkOutput("abort_nled_async", int'(nled1), 1);
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    #1;
    checkOutput("abort_ready_before_edge", int'(tx_ready1), 0);
    @(posedge clk);
    #1;
    checkOutput("abort_ready_after_edge", int'(tx_ready1), 1);
    dones = 0;
    bad   = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done1) dones++;
      if (!txd1 || busy1) bad++;
    end
    checkOutput("abort_no_tx_done", dones, 0);
    checkOutput("abort_no_resume", bad, 0);

    applyStimulus(0, 8'h81, -1, 1, 0, 8'h00);
    waitIdle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
